// File: rtl/stack_controller_pkg.sv
// Shared types and constants for the stack controller and its arbiter.
package stack_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_PUSH = 1'b0;
   localparam logic OP_POP  = 1'b1;

   // Next round-robin pointer after index idx has been served, modulo n.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/stack_controller_if.sv
// Requester-side transaction bus of the stack controller.
//
// Handshake: requester i raises req[i] with req_op[i]/req_data slice stable
// and holds them until ack[i] pulses for one cycle; ack_err and rdata are
// valid in that same cycle. On the edge that ends the ack cycle the
// requester either drops req[i] or presents its next operation; a req still
// high in the following idle cycle starts a new transaction.
interface stack_controller_if #(
   parameter int NREQ = 2,
   parameter int SIZE = 6
);
   logic [NREQ-1:0]      req;
   logic [NREQ-1:0]      req_op;
   logic [NREQ*SIZE-1:0] req_data;
   logic [NREQ-1:0]      ack;
   logic                 ack_err;
   logic [SIZE-1:0]      rdata;

   modport master (
      output req, req_op, req_data,
      input  ack, ack_err, rdata
   );

   modport slave (
      input  req, req_op, req_data,
      output ack, ack_err, rdata
   );
endinterface

// File: rtl/stack_controller_round_robin_arbiter.sv
// Combinational round-robin arbiter: the first requesting index at or after
// prio_ptr (wrapping) wins. The pointer itself is owned by the controller.
module round_robin_arbiter #(
   parameter int NREQ = 2,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   prio_ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   grant_idx
);

   logic found;

   // Scan offsets 0..NREQ-1 from the pointer and take the first active request.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i == (int'(prio_ptr) + k) % NREQ)) begin
               found     = 1'b1;
               grant[i]  = 1'b1;
               grant_idx = IW'(i);
            end
         end
      end
   end

endmodule

// File: rtl/stack_controller.sv
// Arbitration and sequencing front-end for the stack datapath: grants
// requesters round-robin, issues single-cycle push/pop strobes and refuses
// overflow/underflow using the datapath's full/empty flags.
module stack_controller
   import stack_ctrl_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int SIZE  = 6,
   parameter int NREQ  = 2
) (
   input  logic                clk,
   input  logic                reset,
   stack_controller_if.slave   bus,
   output logic                stk_push,
   output logic                stk_pop,
   output logic [SIZE-1:0]     stk_bus_in,
   input  logic [SIZE-1:0]     stk_bus_out,
   input  logic                stk_msb,
   input  logic                stk_zero,
   output logic                full,
   output logic                empty,
   output logic                err_ovf,
   output logic                err_udf,
   input  logic                clear_err,
   output state_t              dbg_state
);

   localparam int IW = $clog2(NREQ);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || NREQ < 2 || NREQ > 4) begin : g_bad_cfg
      $error("stack_controller: DEPTH must be a power of two and NREQ in 2..4");
   end

   state_t          state;
   logic [IW-1:0]   prio_ptr;
   logic [IW-1:0]   g_idx;
   logic [NREQ-1:0] g_oh;
   logic            op_q;
   logic            err_q;

   logic [NREQ-1:0] grant;
   logic [IW-1:0]   grant_idx;
   logic            sel_op;
   logic [SIZE-1:0] sel_data;

   round_robin_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .req       (bus.req),
      .prio_ptr  (prio_ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Pick the winning requester's operation and push word.
   always_comb begin
      sel_op   = OP_PUSH;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_op   = bus.req_op[i];
            sel_data = bus.req_data[i*SIZE +: SIZE];
         end
      end
   end

   // Transaction FSM with registered strobes, ack and sticky error flags.
   // Only this block moves the stack, and its previous strobe was already
   // reflected in the flags by the end of DONE, so msb/zero sampled on the
   // IDLE->EXEC edge equal their values throughout EXEC. That lets the
   // strobe be registered and still appear exactly in the EXEC cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         prio_ptr    <= '0;
         g_idx       <= '0;
         g_oh        <= '0;
         op_q        <= OP_PUSH;
         err_q       <= 1'b0;
         bus.ack     <= '0;
         bus.ack_err <= 1'b0;
         bus.rdata   <= '0;
         stk_push    <= 1'b0;
         stk_pop     <= 1'b0;
         stk_bus_in  <= '0;
         err_ovf     <= 1'b0;
         err_udf     <= 1'b0;
      end else begin
         bus.ack     <= '0;
         bus.ack_err <= 1'b0;
         stk_push    <= 1'b0;
         stk_pop     <= 1'b0;
         stk_bus_in  <= '0;
         // Clear first so a set later in this block wins on the same edge.
         if (clear_err) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (|bus.req) begin
                  g_idx <= grant_idx;
                  g_oh  <= grant;
                  op_q  <= sel_op;
                  state <= EXEC;
                  if (sel_op == OP_PUSH) begin
                     err_q <= stk_msb;
                     if (!stk_msb) begin
                        stk_push   <= 1'b1;
                        stk_bus_in <= sel_data;
                     end
                  end else begin
                     err_q <= stk_zero;
                     if (!stk_zero) stk_pop <= 1'b1;
                  end
               end
            end
            EXEC: begin
               if (err_q) begin
                  if (op_q == OP_PUSH) err_ovf <= 1'b1;
                  else                 err_udf <= 1'b1;
               end
               if (stk_pop) bus.rdata <= stk_bus_out;
               bus.ack     <= g_oh;
               bus.ack_err <= err_q;
               state       <= DONE;
            end
            DONE: begin
               prio_ptr <= IW'(rr_next(int'(g_idx), NREQ));
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign full      = stk_msb;
   assign empty     = stk_zero;
   assign dbg_state = state;

endmodule
